// File: rtl/unpack_serializer.sv
// Word FIFO plus value shifter: buffers extended words from allocate and emits packed values on a valid/ready stream.
// Define UNPACK_VALUE_COUNT_EN to add the pkt_value_count output.
module unpack_serializer #(
    parameter int WORD_WIDTH = 32,
    parameter int DATA_WIDTH = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [WORD_WIDTH+DATA_WIDTH-2:0] word_a,
    input  logic [5:0]                       num_values_a,
    input  logic                             new_word_a,
    input  logic                             first_word_a,
    input  logic                             last_word_a,
    output logic                             fifo_full,
    output logic [DATA_WIDTH-1:0]            data_out,
    output logic                             valid_out,
    input  logic                             out_ready,
    output logic                             sop_out,
    output logic                             eop_out,
    output logic                             busy,
    output logic                             overflow_err,
    output logic                             protocol_err
`ifdef UNPACK_VALUE_COUNT_EN
    ,
    output logic [15:0]                      pkt_value_count
`endif
);
    localparam int XW = WORD_WIDTH + DATA_WIDTH - 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [5:0] MAXV = 6'(XW / DATA_WIDTH);

    typedef enum logic {IDLE, SHIFT} state_e;

    logic [XW-1:0] mem_word_q  [FIFO_DEPTH];
    logic [5:0]    mem_cnt_q   [FIFO_DEPTH];
    logic          mem_first_q [FIFO_DEPTH];
    logic          mem_last_q  [FIFO_DEPTH];

    logic [AW:0]   wptr_q, rptr_q;
    state_e        state_q, state_d;
    logic [XW-1:0] shift_q;
    logic [5:0]    remaining_q, count_q;
    logic          first_pending_q, last_flag_q;
    logic          overflow_q, protocol_q;

    logic          empty, full, push, pop, load, load_first, zero_pop, hs;
    logic [5:0]    cnt_clamp;
    logic [XW-1:0] head_word;
    logic [5:0]    head_cnt;
    logic          head_first, head_last;

    assign cnt_clamp  = (num_values_a > MAXV) ? MAXV : num_values_a;
    assign empty      = (wptr_q == rptr_q);
    assign full       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head_word  = mem_word_q[rptr_q[AW-1:0]];
    assign head_cnt   = mem_cnt_q[rptr_q[AW-1:0]];
    assign head_first = mem_first_q[rptr_q[AW-1:0]];
    assign head_last  = mem_last_q[rptr_q[AW-1:0]];
    // A pop frees the slot on the same edge, so a push into a full FIFO survives it.
    assign push       = new_word_a && (!full || pop);
    assign hs         = (state_q == SHIFT) && out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_word_q[wptr_q[AW-1:0]]  <= word_a;
            mem_cnt_q[wptr_q[AW-1:0]]   <= cnt_clamp;
            mem_first_q[wptr_q[AW-1:0]] <= first_word_a;
            mem_last_q[wptr_q[AW-1:0]]  <= last_word_a;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        load       = 1'b0;
        load_first = 1'b0;
        zero_pop   = 1'b0;
        case (state_q)
            IDLE: if (!empty) begin
                pop = 1'b1;
                if (head_cnt != 6'd0) begin
                    load       = 1'b1;
                    load_first = head_first | first_pending_q;
                    state_d    = SHIFT;
                end else begin
                    zero_pop = 1'b1;
                end
            end
            SHIFT: if (hs && remaining_q == 6'd1) begin
                if (!empty && head_cnt != 6'd0) begin
                    pop        = 1'b1;
                    load       = 1'b1;
                    load_first = head_first;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_out    = (state_q == SHIFT);
        data_out     = valid_out ? shift_q[DATA_WIDTH-1:0] : '0;
        sop_out      = valid_out && first_pending_q && (remaining_q == count_q);
        eop_out      = valid_out && last_flag_q && (remaining_q == 6'd1);
        fifo_full    = full;
        busy         = !empty || valid_out;
        overflow_err = overflow_q;
        protocol_err = protocol_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q          <= '0;
            rptr_q          <= '0;
            shift_q         <= '0;
            remaining_q     <= '0;
            count_q         <= '0;
            first_pending_q <= 1'b0;
            last_flag_q     <= 1'b0;
            overflow_q      <= 1'b0;
            protocol_q      <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (new_word_a && full && !pop) overflow_q <= 1'b1;
            if (load) begin
                shift_q         <= head_word;
                remaining_q     <= head_cnt;
                count_q         <= head_cnt;
                first_pending_q <= load_first;
                last_flag_q     <= head_last;
            end else if (hs) begin
                shift_q         <= shift_q >> DATA_WIDTH;
                remaining_q     <= remaining_q - 6'd1;
                first_pending_q <= 1'b0;
            end
            // An empty entry still hands its packet start to the next emitted value.
            if (zero_pop && head_first) first_pending_q <= 1'b1;
            if (zero_pop && head_last)  protocol_q      <= 1'b1;
        end
    end

`ifdef UNPACK_VALUE_COUNT_EN
    logic [15:0] pvc_q;
    logic        pvc_done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pvc_q      <= '0;
            pvc_done_q <= 1'b0;
        end else if (hs) begin
            if (sop_out) begin
                pvc_q      <= 16'd1;
                pvc_done_q <= eop_out;
            end else if (!pvc_done_q) begin
                if (pvc_q != 16'hFFFF) pvc_q <= pvc_q + 16'd1;
                pvc_done_q <= eop_out;
            end
        end
    end

    assign pkt_value_count = pvc_q;
`endif
endmodule
